// File: rtl/pkg_blackjack.sv
// pkg_blackjack -- shared types and constants for the blackjack round controller.
//   estado_t             : 4-bit state encoding, also exported on the estado debug port
//   LIMITE_21            : bust threshold (a hand above this loses)
//   DEALER_LIMITE_PADRAO : default dealer stand threshold
//   estourou()           : unsigned 6-bit bust test
package pkg_blackjack;

    typedef enum logic [3:0] {
        INICIO      = 4'd0,
        LIMPA       = 4'd1,
        DIST_J1     = 4'd2,
        DIST_D1     = 4'd3,
        DIST_J2     = 4'd4,
        DIST_D2     = 4'd5,
        VEZ_JOGADOR = 4'd6,
        COMPRA_J    = 4'd7,
        VEZ_DEALER  = 4'd8,
        COMPRA_D    = 4'd9,
        COMPARA     = 4'd10,
        FIM         = 4'd11,
        ERRO        = 4'd12
    } estado_t;

    localparam logic [5:0] LIMITE_21            = 6'd21;
    localparam int         DEALER_LIMITE_PADRAO = 17;

    function automatic logic estourou(input logic [5:0] pts);
        return pts > LIMITE_21;
    endfunction

endpackage

// File: rtl/controle_jogo_if.sv
// controle_jogo_if -- card request/score bus between the round controller and
// the scoring block.
//   pjogador / pdealer       : request to score a card for player / dealer
//   cartaok                  : scoring block has scored the requested card
//   pts_jogador / pts_dealer : running scores, valid while cartaok is high
// master = round controller, slave = scoring block.
interface controle_jogo_if;
    logic       pjogador;
    logic       pdealer;
    logic       cartaok;
    logic [5:0] pts_jogador;
    logic [5:0] pts_dealer;

    modport master (output pjogador, pdealer, input cartaok, pts_jogador, pts_dealer);
    modport slave  (input pjogador, pdealer, output cartaok, pts_jogador, pts_dealer);
endinterface

// File: rtl/detector_borda.sv
// detector_borda -- 1-bit rising-edge detector.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   din          : level input
//   borda        : high for the single cycle in which din is first seen high
// The previous-value register clears on reset, so a level already high when
// reset releases counts as an edge.
module detector_borda (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic borda
);

    logic ant_q, ant_d;

    always_comb ant_d = din;

    always_ff @(posedge clock) begin
        if (reset) ant_q <= 1'b0;
        else       ant_q <= ant_d;
    end

    assign borda = din & ~ant_q;

endmodule

// File: rtl/controle_jogo.sv
// controle_jogo -- blackjack round controller.
//   clock, reset              : rising-edge clock, synchronous active-high reset
//   iniciar, hit, stay        : player levels, acted on at their rising edges
//   cartaok, pts_jogador/dealer : scoring block handshake and scores
//   pjogador, pdealer         : card requests (never both high)
//   nova_rodada               : one-cycle clear pulse for the scoring block
//   vitoria/derrota/empate    : registered round result, held through FIM
//   erro                      : cartaok timeout, sticky until reset
//   estado                    : current state encoding
// Parameters: DEALER_LIMITE (dealer draws below it), TIMEOUT_CICLOS (cartaok wait).
// Optional macro BLACKJACK_NATURAL_EN: resolve a natural 21 right after the deal.
module controle_jogo
    import pkg_blackjack::*;
#(
    parameter int DEALER_LIMITE  = DEALER_LIMITE_PADRAO,
    parameter int TIMEOUT_CICLOS = 255
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       hit,
    input  logic       stay,
    input  logic       cartaok,
    input  logic [5:0] pts_jogador,
    input  logic [5:0] pts_dealer,
    output logic       pjogador,
    output logic       pdealer,
    output logic       nova_rodada,
    output logic       vitoria,
    output logic       derrota,
    output logic       empate,
    output logic       erro,
    output logic [3:0] estado
);

    logic borda_iniciar, borda_hit, borda_stay;

    detector_borda u_borda_iniciar (.clock(clock), .reset(reset), .din(iniciar), .borda(borda_iniciar));
    detector_borda u_borda_hit     (.clock(clock), .reset(reset), .din(hit),     .borda(borda_hit));
    detector_borda u_borda_stay    (.clock(clock), .reset(reset), .din(stay),    .borda(borda_stay));

    estado_t    estado_q, estado_d;
    logic       pjogador_q, pjogador_d;
    logic       pdealer_q, pdealer_d;
    logic       nova_q, nova_d;
    logic       vitoria_q, vitoria_d;
    logic       derrota_q, derrota_d;
    logic       empate_q, empate_d;
    logic       erro_q, erro_d;
    logic [7:0] espera_q, espera_d;

    logic       req_ativo, hs_feito, hs_estado, hs_jog;
    logic [7:0] espera_inc;

    always_comb begin
        estado_d   = estado_q;
        pjogador_d = pjogador_q;
        pdealer_d  = pdealer_q;
        vitoria_d  = vitoria_q;
        derrota_d  = derrota_q;
        empate_d   = empate_q;
        erro_d     = erro_q;
        hs_estado  = 1'b0;
        hs_jog     = 1'b0;

        req_ativo  = pjogador_q | pdealer_q;
        hs_feito   = req_ativo & cartaok;
        espera_inc = espera_q + 8'd1;

        // Wait counter: runs while a request is unanswered, holds on the
        // answering cycle, clears once the request is down.
        espera_d = 8'd0;
        if (req_ativo && !cartaok) espera_d = espera_inc;
        else if (req_ativo)        espera_d = espera_q;

        case (estado_q)
            DIST_J1, DIST_J2, COMPRA_J: begin hs_estado = 1'b1; hs_jog = 1'b1; end
            DIST_D1, DIST_D2, COMPRA_D: hs_estado = 1'b1;
            default: ;
        endcase

        // Shared handshake: drop on cartaok; a state entered right after a
        // completed handshake raises its request only once cartaok is seen low.
        if (hs_estado) begin
            if (req_ativo) begin
                if (cartaok) begin
                    pjogador_d = 1'b0;
                    pdealer_d  = 1'b0;
                end
            end else begin
                pjogador_d = hs_jog & ~cartaok;
                pdealer_d  = ~hs_jog & ~cartaok;
            end
        end

        case (estado_q)
            INICIO: if (borda_iniciar) estado_d = LIMPA;
            LIMPA: begin
                estado_d   = DIST_J1;
                pjogador_d = ~cartaok;
            end
            DIST_J1: if (hs_feito) estado_d = DIST_D1;
            DIST_D1: if (hs_feito) estado_d = DIST_J2;
            DIST_J2: if (hs_feito) estado_d = DIST_D2;
            DIST_D2: if (hs_feito) begin
`ifdef BLACKJACK_NATURAL_EN
                if (pts_jogador == LIMITE_21 && pts_dealer == LIMITE_21) begin
                    estado_d  = FIM;
                    vitoria_d = 1'b0;
                    derrota_d = 1'b0;
                    empate_d  = 1'b1;
                end else if (pts_jogador == LIMITE_21) begin
                    estado_d  = FIM;
                    vitoria_d = 1'b1;
                    derrota_d = 1'b0;
                    empate_d  = 1'b0;
                end else begin
                    estado_d = VEZ_JOGADOR;
                end
`else
                estado_d = VEZ_JOGADOR;
`endif
            end
            VEZ_JOGADOR: begin
                // stay has priority when both edges land together
                if (borda_stay) begin
                    estado_d = VEZ_DEALER;
                end else if (borda_hit) begin
                    estado_d   = COMPRA_J;
                    pjogador_d = ~cartaok;
                end
            end
            COMPRA_J: if (hs_feito) begin
                if (estourou(pts_jogador)) begin
                    estado_d  = FIM;
                    vitoria_d = 1'b0;
                    derrota_d = 1'b1;
                    empate_d  = 1'b0;
                end else begin
                    estado_d = VEZ_JOGADOR;
                end
            end
            VEZ_DEALER: begin
                if (pts_dealer < 6'(DEALER_LIMITE)) begin
                    estado_d  = COMPRA_D;
                    pdealer_d = ~cartaok;
                end else begin
                    estado_d = COMPARA;
                end
            end
            COMPRA_D: if (hs_feito) estado_d = VEZ_DEALER;
            COMPARA: begin
                estado_d  = FIM;
                vitoria_d = 1'b0;
                derrota_d = 1'b0;
                empate_d  = 1'b0;
                if (estourou(pts_dealer))            vitoria_d = 1'b1;
                else if (pts_jogador > pts_dealer)   vitoria_d = 1'b1;
                else if (pts_jogador < pts_dealer)   derrota_d = 1'b1;
                else                                 empate_d  = 1'b1;
            end
            FIM:  if (borda_iniciar) estado_d = LIMPA;
            ERRO: estado_d = ERRO;
            default: estado_d = INICIO;
        endcase

        if (estado_d == LIMPA) begin
            vitoria_d = 1'b0;
            derrota_d = 1'b0;
            empate_d  = 1'b0;
        end

        // Timeout overrides whatever the handshake state wanted this cycle.
        if (req_ativo && !cartaok && espera_inc == 8'(TIMEOUT_CICLOS)) begin
            estado_d   = ERRO;
            pjogador_d = 1'b0;
            pdealer_d  = 1'b0;
        end

        if (estado_d == ERRO) erro_d = 1'b1;
        nova_d = (estado_d == LIMPA);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q   <= INICIO;
            pjogador_q <= 1'b0;
            pdealer_q  <= 1'b0;
            nova_q     <= 1'b0;
            vitoria_q  <= 1'b0;
            derrota_q  <= 1'b0;
            empate_q   <= 1'b0;
            erro_q     <= 1'b0;
            espera_q   <= 8'd0;
        end else begin
            estado_q   <= estado_d;
            pjogador_q <= pjogador_d;
            pdealer_q  <= pdealer_d;
            nova_q     <= nova_d;
            vitoria_q  <= vitoria_d;
            derrota_q  <= derrota_d;
            empate_q   <= empate_d;
            erro_q     <= erro_d;
            espera_q   <= espera_d;
        end
    end

    assign pjogador    = pjogador_q;
    assign pdealer     = pdealer_q;
    assign nova_rodada = nova_q;
    assign vitoria     = vitoria_q;
    assign derrota     = derrota_q;
    assign empate      = empate_q;
    assign erro        = erro_q;
    assign estado      = estado_q;

endmodule
